fwd_hazard_ctrl: RTL

- Pipeline controller that drives the select inputs of the two EX-stage 3-input operand muxes.
- Encoding: 00 = register file, 01 = EX/MEM result, 10 = MEM/WB result.
- Also detects load-use hazards, handles branch flushes and multi-cycle data-memory waits, and issues stall/bubble/freeze controls to the 5-stage RISC-V core.
- Keeps its own shadow copy of rd/rs/control bits for the EX, MEM and WB stages, so it needs only ID-stage decode information.

---
 rtl/fwd_hazard_ctrl_pkg.sv | 26 ++
 rtl/fwd_hazard_ctrl_fwd_select_unit.sv | 30 +++
 rtl/fwd_hazard_ctrl.sv | 123 ++++++++++++
 3 files changed

// File: rtl/fwd_hazard_ctrl_pkg.sv
// Shared types for the forwarding / hazard controller: mux select codes,
// controller states and the per-stage shadow record.
package fwd_hazard_ctrl_pkg;

   localparam int SH_AW = 5;

   localparam logic [1:0] FWD_RF    = 2'b00;
   localparam logic [1:0] FWD_EXMEM = 2'b01;
   localparam logic [1:0] FWD_MEMWB = 2'b10;

   typedef enum logic [1:0] {
      ST_RUN        = 2'd0,
      ST_LOAD_STALL = 2'd1,
      ST_MEM_WAIT   = 2'd2
   } state_t;

   typedef struct packed {
      logic             valid;
      logic [SH_AW-1:0] rs1;
      logic [SH_AW-1:0] rs2;
      logic [SH_AW-1:0] rd;
      logic             reg_write;
      logic             mem_read;
   } stage_t;

endpackage

// File: rtl/fwd_hazard_ctrl_fwd_select_unit.sv
// Operand-forwarding match for one EX operand; the MEM-stage producer
// shadows the WB-stage producer so the newest value wins.
module fwd_select_unit
   import fwd_hazard_ctrl_pkg::*;
#(
   parameter int REG_AW = SH_AW
) (
   input  logic [REG_AW-1:0] i_src,
   input  stage_t            i_mem,
   input  stage_t            i_wb,
   output logic [1:0]        o_sel
);

   logic w_mem_hit;
   logic w_wb_hit;

   assign w_mem_hit = i_mem.valid & i_mem.reg_write & (i_mem.rd != '0) & (i_mem.rd == i_src);
   assign w_wb_hit  = i_wb.valid  & i_wb.reg_write  & (i_wb.rd  != '0) & (i_wb.rd  == i_src);

   always_comb begin
      // NOTE: default first so every path assigns o_sel and no latch is inferred.
      o_sel = FWD_RF;
      if (w_mem_hit) begin
         o_sel = FWD_EXMEM;
      end else if (w_wb_hit) begin
         o_sel = FWD_MEMWB;
      end
   end

endmodule

// File: rtl/fwd_hazard_ctrl.sv
// Forwarding-select, load-use, branch-flush and memory-wait controller for a
// 5-stage core; tracks EX/MEM/WB with its own shadow copies of ID decode.
module fwd_hazard_ctrl
   import fwd_hazard_ctrl_pkg::*;
#(
   parameter int REG_AW = SH_AW,
   parameter int CNT_W  = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              id_valid,
   input  logic [REG_AW-1:0] id_rs1,
   input  logic [REG_AW-1:0] id_rs2,
   input  logic [REG_AW-1:0] id_rd,
   input  logic              id_reg_write,
   input  logic              id_mem_read,
   input  logic              branch_flush,
   input  logic              mem_busy,
   output logic [1:0]        fwd_sel_a,
   output logic [1:0]        fwd_sel_b,
   output logic              stall_if_id,
   output logic              bubble_ex,
   output logic              freeze_all,
   output logic              flush_if_id,
   output logic [CNT_W-1:0]  stall_cnt
);

   state_t             r_state;
   state_t             w_state_nxt;
   stage_t             r_ex;
   stage_t             r_mem;
   stage_t             r_wb;
   stage_t             w_id;
   logic [CNT_W-1:0]   r_cnt;
   logic               w_hazard;
   logic               w_freeze;
   logic               w_flush;
   logic               w_stall;
   logic               w_bubble;

   assign w_id = '{valid:     id_valid,
                   rs1:       id_rs1,
                   rs2:       id_rs2,
                   rd:        id_rd,
                   reg_write: id_reg_write,
                   mem_read:  id_mem_read};

   assign w_hazard = id_valid & r_ex.valid & r_ex.mem_read & (r_ex.rd != '0) &
                     ((r_ex.rd == id_rs1) | (r_ex.rd == id_rs2));

   fwd_select_unit #(.REG_AW(REG_AW)) u_fwd_a (
      .i_src (r_ex.rs1),
      .i_mem (r_mem),
      .i_wb  (r_wb),
      .o_sel (fwd_sel_a)
   );

   fwd_select_unit #(.REG_AW(REG_AW)) u_fwd_b (
      .i_src (r_ex.rs2),
      .i_mem (r_mem),
      .i_wb  (r_wb),
      .o_sel (fwd_sel_b)
   );

   // Leaving MEM_WAIT is evaluated exactly like RUN; LOAD_STALL never re-enters itself.
   always_comb begin
      w_state_nxt = ST_RUN;
      w_freeze    = 1'b0;
      w_flush     = 1'b0;
      w_stall     = 1'b0;
      w_bubble    = 1'b0;
      if (mem_busy) begin
         w_freeze    = 1'b1;
         w_state_nxt = ST_MEM_WAIT;
      end else if (branch_flush) begin
         w_flush  = 1'b1;
         w_bubble = 1'b1;
      end else if (w_hazard) begin
         w_stall  = 1'b1;
         w_bubble = 1'b1;
         if (r_state != ST_LOAD_STALL) begin
            w_state_nxt = ST_LOAD_STALL;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= ST_RUN;
      end else begin
         // NOTE: sequential state uses non-blocking assignment so every register samples pre-edge values.
         r_state <= w_state_nxt;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_ex  <= '0;
         r_mem <= '0;
         r_wb  <= '0;
      end else if (!w_freeze) begin
         r_wb  <= r_mem;
         r_mem <= r_ex;
         r_ex  <= w_bubble ? '0 : w_id;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cnt <= '0;
      end else if ((w_stall | w_freeze) && (r_cnt != '1)) begin
         r_cnt <= r_cnt + 1'b1;
      end
   end

   // Control strobes are forced low while reset is held, whatever the inputs do.
   assign stall_if_id = w_stall  & ~rst;
   assign bubble_ex   = w_bubble & ~rst;
   assign freeze_all  = w_freeze & ~rst;
   assign flush_if_id = w_flush  & ~rst;
   assign stall_cnt   = r_cnt;

endmodule
